count_sampler: RTL and testbench
================================

COUNT_SAMPLER -- requirements
Module: count_sampler

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of FIFO entries (power of two, minimum 2).
REQ-002 SHALL have parameter WIDTH, default 8, meaning the width of the monitored count value.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port value  input  WIDTH  count value from the upstream counter, sampled every clk.
REQ-006 SHALL have port sample  input  1  single-cycle request to capture value.
REQ-007 SHALL have port out_data  output  WIDTH  head-entry data.
REQ-008 SHALL have port out_tag  output  2  head-entry tag: 0 = sample, 1 = wrap, 2 = restart, 3 unused.
REQ-009 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the head entry when out_valid=1.
REQ-011 SHALL have port drop_cnt  output  8  count of discarded entries, saturating at 255.
REQ-012 SHALL have port overflow  output  1  sticky flag, set on any discard.

Function
REQ-013 SHALL register value into prev every cycle and set prev_valid=1 on the first clk edge after reset release.
REQ-014 SHALL detect a wrap when prev_valid=1, prev=all-ones and value=0; the event data is 0.
REQ-015 SHALL detect a restart when prev_valid=1, value<prev (unsigned) and the cycle is not a wrap; the event data is value.
REQ-016 SHALL NOT detect any event while prev_valid=0.
REQ-017 SHALL form at most one push candidate per cycle, in priority order: wrap, restart, sample (data = value, tag 0).
REQ-018 SHALL treat a sample coincident with a wrap or restart as a discard (drop_cnt +1, overflow set); the event is still pushed.
REQ-019 SHALL write each push into the FIFO at the clk edge; out_valid rises on the next cycle, with no combinational fall-through.
REQ-020 SHALL pop the head entry at a clk edge when out_valid=1 and out_ready=1; a pop while empty has no effect.
REQ-021 SHALL accept a push when the FIFO is full only if a pop occurs in the same cycle; otherwise the push is discarded (drop_cnt +1 saturating, overflow set).
REQ-022 SHALL keep occupancy unchanged on a simultaneous push and pop at any non-full, non-empty level.
REQ-023 SHALL count two discards in one cycle (collision plus full) as 2, saturating at 255.
REQ-024 SHALL drive out_data and out_tag from the head entry when out_valid=1, and force both to 0 when out_valid=0.
REQ-025 SHALL wrap the FIFO read and write pointers modulo DEPTH, with full/empty resolved by an extra pointer bit.
REQ-026 SHALL preserve entry order (FIFO) and hold a stalled head stable while out_ready=0.

Reset
REQ-027 SHALL, while reset=1, asynchronously clear the pointers, prev=0, prev_valid=0, drop_cnt=0 and overflow=0, giving out_valid=0, out_data=0 and out_tag=0.
REQ-028 SHALL discard all FIFO contents on reset mid-operation and accept no push during reset.
REQ-029 SHALL NOT report the upstream counter's return to 0 after a shared reset as a restart, because prev_valid=0 suppresses it.

Verification
REQ-030 Free-running counter, out_ready=1, sample pulse at value=0x05: one cycle later out_valid=1, out_data=0x05, out_tag=0; entry gone the following cycle.
REQ-031 Counter steps 0xFE, 0xFF, 0x00: one wrap entry, out_data=0x00, out_tag=1; no restart entry.
REQ-032 Upstream counter reset pulse at value=0x2A (next value 0x00): one restart entry, out_data=0x00, out_tag=2; block's own reset asserted with it: no entry.
REQ-033 out_ready=0, six samples with DEPTH=4: entries 1-4 retained in order; drop_cnt=2, overflow=1; out_ready=1 then drains exactly 4 entries in order.
REQ-034 Full FIFO with out_ready=1 and a sample in the same cycle: push accepted, occupancy stays 4, drop_cnt unchanged.
REQ-035 Sample coincident with wrap: wrap entry pushed, drop_cnt +1; assert reset mid-drain: out_valid=0, drop_cnt=0 and overflow=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/count_sampler_if.sv
// Bundle carrying the counter input, the sample request and the FIFO head
// handshake of count_sampler. The master side is the sampler itself; the
// slave side is whoever drives the counter and consumes the entries.
interface count_sampler_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] value;
  logic             sample;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_tag;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       drop_cnt;
  logic             overflow;

  modport master (
    input  value,
    input  sample,
    input  out_ready,
    output out_data,
    output out_tag,
    output out_valid,
    output drop_cnt,
    output overflow
  );

  modport slave (
    output value,
    output sample,
    output out_ready,
    input  out_data,
    input  out_tag,
    input  out_valid,
    input  drop_cnt,
    input  overflow
  );
endinterface

// File: rtl/count_sampler.sv
// Monitors a free-running counter. It records explicit samples, wraps and
// unexpected restarts as tagged entries in a small FIFO. Entries that cannot
// be stored are counted in a saturating drop counter and flagged as overflow.
module count_sampler #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             reset,
  count_sampler_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    TagSample  = 2'd0,
    TagWrap    = 2'd1,
    TagRestart = 2'd2
  } tag_e;

  // Previous counter value and its validity.
  logic [WIDTH-1:0] prev_q;
  logic             prev_valid_q;

  // FIFO storage and pointers; the extra MSB separates full from empty.
  logic [WIDTH-1:0] mem_data_q [DEPTH];
  logic [1:0]       mem_tag_q  [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;

  logic             wrap, restart, collision;
  logic             push, push_ok, push_drop, pop;
  logic [WIDTH-1:0] push_data;
  tag_e             push_tag;
  logic             empty, full;
  logic [1:0]       drop_inc;
  logic [8:0]       drop_sum;

  // Event detection; nothing fires until a previous value has been captured.
  always_comb begin
    wrap      = prev_valid_q && (prev_q == '1) && (bus.value == '0);
    restart   = prev_valid_q && (bus.value < prev_q) && !wrap;
    collision = bus.sample && (wrap || restart);
  end

  // Select a single push candidate: wrap beats restart beats sample.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    push_tag  = TagSample;
    if (wrap) begin
      push      = 1'b1;
      push_data = '0;
      push_tag  = TagWrap;
    end else if (restart) begin
      push      = 1'b1;
      push_data = bus.value;
      push_tag  = TagRestart;
    end else if (bus.sample) begin
      push      = 1'b1;
      push_data = bus.value;
      push_tag  = TagSample;
    end
  end

  // FIFO status, handshake and pointer next state.
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop       = !empty && bus.out_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_ok   = push && (!full || pop);
    push_drop = push && !push_ok;
    wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  // Discard accounting; a collision and a full-FIFO drop can add up to 2.
  always_comb begin
    drop_inc   = {1'b0, collision} + {1'b0, push_drop};
    drop_sum   = {1'b0, drop_cnt_q} + {7'b0, drop_inc};
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    overflow_d = overflow_q | (drop_inc != 2'd0);
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      prev_q       <= bus.value;
      prev_valid_q <= 1'b1;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      drop_cnt_q   <= drop_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  // Entry storage; contents are don't-care until the pointers mark them valid.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      mem_data_q[wr_ptr_q[AW-1:0]] <= push_data;
      mem_tag_q[wr_ptr_q[AW-1:0]]  <= push_tag;
    end
  end

  // Head entry output, forced to zero when nothing is queued.
  always_comb begin
    bus.out_valid = !empty;
    bus.out_data  = empty ? '0 : mem_data_q[rd_ptr_q[AW-1:0]];
    bus.out_tag   = empty ? 2'd0 : mem_tag_q[rd_ptr_q[AW-1:0]];
    bus.drop_cnt  = drop_cnt_q;
    bus.overflow  = overflow_q;
  end

endmodule

// File: tb/tb_count_sampler.sv
// Directed bench for count_sampler (DEPTH=4, WIDTH=8): a vector table for the
// main flow plus hand-written sequences for collisions, reset and saturation.
module tb_count_sampler;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  count_sampler_if #(.WIDTH(8)) bus ();

  count_sampler #(
    .DEPTH(4),
    .WIDTH(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] value;
    logic       sample;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [1:0] exp_tag;
    logic [7:0] exp_drop;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic v, input logic [7:0] d,
                         input logic [1:0] t, input logic [7:0] dc, input logic o);
    chk({name, ".valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    chk({name, ".data"}, {24'd0, bus.out_data}, {24'd0, d});
    chk({name, ".tag"}, {30'd0, bus.out_tag}, {30'd0, t});
    chk({name, ".drop"}, {24'd0, bus.drop_cnt}, {24'd0, dc});
    chk({name, ".ovf"}, {31'd0, bus.overflow}, {31'd0, o});
  endtask

  // Drive inputs away from the edge, clock once, settle.
  task automatic step(input logic [7:0] v, input logic s, input logic r);
    bus.value     = v;
    bus.sample    = s;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //              value  smp  rdy  vld  data   tag   drop  ovf
    vecs[0]  = '{8'h03, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 8'd0, 1'b0};
    vecs[1]  = '{8'h04, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 8'd0, 1'b0};
    vecs[2]  = '{8'h05, 1'b1, 1'b1, 1'b1, 8'h05, 2'd0, 8'd0, 1'b0};
    vecs[3]  = '{8'h06, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 8'd0, 1'b0};
    vecs[4]  = '{8'hFE, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 8'd0, 1'b0};
    vecs[5]  = '{8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 8'd0, 1'b0};
    vecs[6]  = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 2'd1, 8'd0, 1'b0};
    vecs[7]  = '{8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 8'd0, 1'b0};
    vecs[8]  = '{8'h2A, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 8'd0, 1'b0};
    vecs[9]  = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 2'd2, 8'd0, 1'b0};
    vecs[10] = '{8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 8'd0, 1'b0};
    vecs[11] = '{8'h10, 1'b1, 1'b0, 1'b1, 8'h10, 2'd0, 8'd0, 1'b0};
    vecs[12] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h10, 2'd0, 8'd0, 1'b0};
    vecs[13] = '{8'h12, 1'b1, 1'b0, 1'b1, 8'h10, 2'd0, 8'd0, 1'b0};
    vecs[14] = '{8'h13, 1'b1, 1'b0, 1'b1, 8'h10, 2'd0, 8'd0, 1'b0};
    vecs[15] = '{8'h14, 1'b1, 1'b0, 1'b1, 8'h10, 2'd0, 8'd1, 1'b1};
    vecs[16] = '{8'h15, 1'b1, 1'b0, 1'b1, 8'h10, 2'd0, 8'd2, 1'b1};
    vecs[17] = '{8'h16, 1'b1, 1'b1, 1'b1, 8'h11, 2'd0, 8'd2, 1'b1};
    vecs[18] = '{8'h17, 1'b0, 1'b1, 1'b1, 8'h12, 2'd0, 8'd2, 1'b1};
    vecs[19] = '{8'h18, 1'b0, 1'b1, 1'b1, 8'h13, 2'd0, 8'd2, 1'b1};
    vecs[20] = '{8'h19, 1'b0, 1'b1, 1'b1, 8'h16, 2'd0, 8'd2, 1'b1};
    vecs[21] = '{8'h1A, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 8'd2, 1'b1};
    vecs[22] = '{8'h05, 1'b1, 1'b0, 1'b1, 8'h05, 2'd2, 8'd3, 1'b1};
    vecs[23] = '{8'h06, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 8'd3, 1'b1};

    // Reset state, asserted from time zero.
    reset         = 1'b1;
    bus.value     = 8'h00;
    bus.sample    = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    chk_out("reset", 1'b0, 8'h00, 2'd0, 8'd0, 1'b0);
    step(8'h00, 1'b0, 1'b1);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      step(vecs[i].value, vecs[i].sample, vecs[i].ready);
      chk_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
              vecs[i].exp_tag, vecs[i].exp_drop, vecs[i].exp_ovf);
    end

    // Sample coincident with a wrap: wrap wins, sample counts as a discard.
    step(8'hFE, 1'b0, 1'b0);
    step(8'hFF, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    chk_out("wrap_coll", 1'b1, 8'h00, 2'd1, 8'd4, 1'b1);
    step(8'h01, 1'b1, 1'b0);
    chk_out("wrap_coll_hold", 1'b1, 8'h00, 2'd1, 8'd4, 1'b1);
    step(8'h02, 1'b0, 1'b1);
    chk_out("drain_one", 1'b1, 8'h01, 2'd0, 8'd4, 1'b1);

    // Reset mid-drain clears everything without a clock edge.
    bus.value = 8'h2A;
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_reset", 1'b0, 8'h00, 2'd0, 8'd0, 1'b0);

    // Upstream counter returns to 0 under the shared reset: no restart.
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    chk_out("in_reset", 1'b0, 8'h00, 2'd0, 8'd0, 1'b0);
    reset = 1'b0;
    step(8'h00, 1'b0, 1'b1);
    step(8'h01, 1'b0, 1'b1);
    chk_out("shared_reset", 1'b0, 8'h00, 2'd0, 8'd0, 1'b0);

    // Fill, then a restart with a sample into a full FIFO: two discards.
    for (int i = 0; i < 4; i++) step(8'h50, 1'b1, 1'b0);
    chk_out("fill", 1'b1, 8'h50, 2'd0, 8'd0, 1'b0);
    step(8'h40, 1'b1, 1'b0);
    chk_out("double_drop", 1'b1, 8'h50, 2'd0, 8'd2, 1'b1);

    // Keep discarding until the counter saturates; head stays stalled.
    for (int i = 0; i < 300; i++) step(8'h40, 1'b1, 1'b0);
    chk_out("saturate", 1'b1, 8'h50, 2'd0, 8'd255, 1'b1);

    // Drain the four stored samples.
    for (int i = 0; i < 3; i++) begin
      step(8'h40, 1'b0, 1'b1);
      chk_out($sformatf("final_drain%0d", i), 1'b1, 8'h50, 2'd0, 8'd255, 1'b1);
    end
    step(8'h40, 1'b0, 1'b1);
    chk_out("final_empty", 1'b0, 8'h00, 2'd0, 8'd255, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
